la_capture_core: RTL and testbench

//  Parametrised on-chip logic-analyzer capture engine for probing design nets (e.g. LCD CS/SCL/SDA).

---
 rtl/la_capture_core.sv | 180 ++++++++++++++++++
 tb/tb_la_capture_core.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/la_capture_core.sv
// Logic-analyzer capture engine: circular sample RAM with a programmable pre/post split around a trigger.
// Optional `LA_TRIG_CNT_EN adds trig_cnt_i so that the trigger fires on the (N+1)-th qualifying event.
module la_capture_core #(
    parameter int DATA_W = 3,
    parameter int DEPTH  = 256,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic [DATA_W-1:0] probe_i,
    input  logic              arm_i,
    input  logic [DATA_W-1:0] trig_mask_i,
    input  logic [DATA_W-1:0] trig_value_i,
    input  logic              trig_mode_i,
    input  logic [ADDR_W-1:0] pre_trig_i,
`ifdef LA_TRIG_CNT_EN
    input  logic [7:0]        trig_cnt_i,
`endif
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic [DATA_W-1:0] rd_data_o,
    output logic              busy_o,
    output logic              done_o,
    output logic [ADDR_W-1:0] trig_pos_o
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRE,
        ST_WAIT,
        ST_POST,
        ST_DONE
    } state_t;

    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(DEPTH - 1);

    state_t            state_reg;
    logic [ADDR_W-1:0] wr_ptr_reg;
    logic [ADDR_W-1:0] cnt_reg;
    logic [ADDR_W-1:0] pre_reg;
    logic [ADDR_W-1:0] trig_pos_reg;
    logic [DATA_W-1:0] mask_reg;
    logic [DATA_W-1:0] value_reg;
    logic              mode_reg;
    logic              match_prev_reg;
    logic              busy_reg;
    logic              done_reg;
    logic [DATA_W-1:0] rd_data_reg;

    logic [DATA_W-1:0] mem [DEPTH];

    logic [DATA_W-1:0] bit_miss;
    logic              match;
    logic              qual;
    logic              fire;
    logic              wr_en;
    logic [ADDR_W-1:0] post_last;
    logic [ADDR_W-1:0] rd_phys;

    genvar gi;
    generate
        for (gi = 0; gi < DATA_W; gi++) begin : g_cmp
            assign bit_miss[gi] = mask_reg[gi] & (probe_i[gi] ^ value_reg[gi]);
        end
    endgenerate

    assign match = (bit_miss == '0);
    assign qual  = mode_reg ? (match & ~match_prev_reg) : match;

`ifdef LA_TRIG_CNT_EN
    logic [7:0] trig_cnt_reg;
    logic [7:0] evt_cnt_reg;
    assign fire = qual && (evt_cnt_reg == trig_cnt_reg);
`else
    assign fire = qual;
`endif

    // An arm cycle never writes; the first sample lands on the following cycle.
    assign wr_en     = !sys_rst && !arm_i &&
                       (state_reg == ST_PRE || state_reg == ST_WAIT || state_reg == ST_POST);
    assign post_last = ADDR_LAST - pre_reg;
    assign rd_phys   = trig_pos_reg - pre_reg + rd_addr_i;

    always_ff @(posedge sys_clk) begin
        if (wr_en) begin
            mem[wr_ptr_reg] <= probe_i;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            rd_data_reg <= '0;
        end else begin
            rd_data_reg <= mem[rd_phys];
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_reg      <= ST_IDLE;
            wr_ptr_reg     <= '0;
            cnt_reg        <= '0;
            pre_reg        <= '0;
            trig_pos_reg   <= '0;
            mask_reg       <= '0;
            value_reg      <= '0;
            mode_reg       <= 1'b0;
            match_prev_reg <= 1'b0;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
`ifdef LA_TRIG_CNT_EN
            trig_cnt_reg   <= '0;
            evt_cnt_reg    <= '0;
`endif
        end else if (arm_i) begin
            mask_reg       <= trig_mask_i;
            value_reg      <= trig_value_i;
            mode_reg       <= trig_mode_i;
            pre_reg        <= pre_trig_i;
            wr_ptr_reg     <= '0;
            cnt_reg        <= '0;
            match_prev_reg <= 1'b0;
            busy_reg       <= 1'b1;
            done_reg       <= 1'b0;
            state_reg      <= (pre_trig_i == '0) ? ST_WAIT : ST_PRE;
`ifdef LA_TRIG_CNT_EN
            trig_cnt_reg   <= trig_cnt_i;
            evt_cnt_reg    <= '0;
`endif
        end else begin
            match_prev_reg <= match;
            case (state_reg)
                ST_PRE: begin
                    wr_ptr_reg <= wr_ptr_reg + ADDR_ONE;
                    cnt_reg    <= cnt_reg + ADDR_ONE;
                    if (cnt_reg == pre_reg - ADDR_ONE) begin
                        state_reg <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    wr_ptr_reg <= wr_ptr_reg + ADDR_ONE;
                    if (fire) begin
                        trig_pos_reg <= wr_ptr_reg;
                        cnt_reg      <= ADDR_ONE;
                        if (pre_reg == ADDR_LAST) begin
                            state_reg <= ST_DONE;
                            busy_reg  <= 1'b0;
                            done_reg  <= 1'b1;
                        end else begin
                            state_reg <= ST_POST;
                        end
                    end
`ifdef LA_TRIG_CNT_EN
                    else if (qual) begin
                        evt_cnt_reg <= evt_cnt_reg + 8'd1;
                    end
`endif
                end
                ST_POST: begin
                    wr_ptr_reg <= wr_ptr_reg + ADDR_ONE;
                    if (cnt_reg == post_last) begin
                        state_reg <= ST_DONE;
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                    end else begin
                        cnt_reg <= cnt_reg + ADDR_ONE;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign rd_data_o  = rd_data_reg;
    assign busy_o     = busy_reg;
    assign done_o     = done_reg;
    assign trig_pos_o = trig_pos_reg;

endmodule

// File: tb/tb_la_capture_core.sv
// Directed bench for la_capture_core (DATA_W=3, DEPTH=16): read-back tables plus multi-cycle corner sequences.
module tb_la_capture_core;

    logic       sys_clk = 1'b0;
    logic       sys_rst;
    logic [2:0] probe;
    logic       arm;
    logic [2:0] trig_mask;
    logic [2:0] trig_value;
    logic       trig_mode;
    logic [3:0] pre_trig;
    logic [7:0] trig_cnt;
    logic [3:0] rd_addr;
    logic [2:0] rd_data;
    logic       busy;
    logic       done;
    logic [3:0] trig_pos;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0] addr;
        logic [2:0] exp;
    } rd_vec_t;

    rd_vec_t lvl_tab[16];
    rd_vec_t edge_tab[5];
    rd_vec_t rst_tab[5];

    la_capture_core #(
        .DATA_W(3),
        .DEPTH (16)
    ) dut (
        .sys_clk     (sys_clk),
        .sys_rst     (sys_rst),
        .probe_i     (probe),
        .arm_i       (arm),
        .trig_mask_i (trig_mask),
        .trig_value_i(trig_value),
        .trig_mode_i (trig_mode),
        .pre_trig_i  (pre_trig),
`ifdef LA_TRIG_CNT_EN
        .trig_cnt_i  (trig_cnt),
`endif
        .rd_addr_i   (rd_addr),
        .rd_data_o   (rd_data),
        .busy_o      (busy),
        .done_o      (done),
        .trig_pos_o  (trig_pos)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    task automatic rd_check(input string name, input logic [3:0] addr, input logic [2:0] exp);
        rd_addr = addr;
        tick();
        check($sformatf("%s[%0d]", name, addr), {29'd0, rd_data}, {29'd0, exp});
    endtask

    task automatic arm_with(input logic [3:0] pre, input logic [2:0] mask, input logic [2:0] value,
                            input logic mode, input logic [2:0] p);
        pre_trig   = pre;
        trig_mask  = mask;
        trig_value = value;
        trig_mode  = mode;
        probe      = p;
        arm        = 1'b1;
        tick();
        arm        = 1'b0;
    endtask

    initial begin
        logic saw_done;
        logic [2:0] lvl_exp [16];
        lvl_exp = '{3'd5, 3'd6, 3'd7, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4,
                    3'd5, 3'd6, 3'd7, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4};
        for (int i = 0; i < 16; i++) begin
            lvl_tab[i].addr = 4'(i);
            lvl_tab[i].exp  = lvl_exp[i];
        end
        edge_tab = '{'{4'd0, 3'b111}, '{4'd1, 3'b010}, '{4'd2, 3'b101},
                     '{4'd3, 3'b011}, '{4'd15, 3'b011}};
        rst_tab  = '{'{4'd0, 3'b001}, '{4'd1, 3'b010}, '{4'd2, 3'b011},
                     '{4'd3, 3'b101}, '{4'd4, 3'b100}};

        sys_rst = 1'b1; probe = '0; arm = 1'b0; trig_mask = '0; trig_value = '0;
        trig_mode = 1'b0; pre_trig = '0; trig_cnt = '0; rd_addr = '0;

        // Reset state
        tick(); tick();
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_trig_pos", {28'd0, trig_pos}, 32'd0);
        check("rst_rd_data", {29'd0, rd_data}, 32'd0);
        sys_rst = 1'b0;
        tick();

        // Level trigger: counting probe, trigger on 3'b??1 with bit2=0 after 4 pre samples
        arm_with(4'd4, 3'b101, 3'b001, 1'b0, 3'd0);
        for (int k = 1; k <= 20; k++) begin
            probe = 3'(k % 8);
            tick();
            if (k == 9) check("lvl_trig_pos", {28'd0, trig_pos}, 32'd8);
            if (k == 19) begin
                check("lvl_busy_before_end", {31'd0, busy}, 32'd1);
                check("lvl_done_before_end", {31'd0, done}, 32'd0);
            end
        end
        check("lvl_done", {31'd0, done}, 32'd1);
        check("lvl_busy_after", {31'd0, busy}, 32'd0);
        probe = 3'd7;
        for (int i = 0; i < 16; i++) rd_check("lvl_rd", lvl_tab[i].addr, lvl_tab[i].exp);

        // Edge trigger: held-high match must not fire, a fresh rise must
        arm_with(4'd2, 3'b001, 3'b001, 1'b1, 3'b111);
        check("edge_done_cleared", {31'd0, done}, 32'd0);
        for (int k = 1; k <= 23; k++) begin
            probe = (k <= 8) ? 3'b111 : (k == 9) ? 3'b010 : (k == 10) ? 3'b101 : 3'b011;
            tick();
            if (k == 8) check("edge_no_fire_held", {28'd0, trig_pos}, 32'd8);
            if (k == 10) check("edge_trig_pos", {28'd0, trig_pos}, 32'd9);
            if (k == 22) check("edge_done_before_end", {31'd0, done}, 32'd0);
        end
        check("edge_done", {31'd0, done}, 32'd1);
        for (int i = 0; i < 5; i++) rd_check("edge_rd", edge_tab[i].addr, edge_tab[i].exp);

        // Wrap: pre_trig=DEPTH-1, trigger after 40 samples goes straight to DONE
        arm_with(4'd15, 3'b111, 3'b110, 1'b0, 3'd0);
        for (int k = 1; k <= 40; k++) begin
            probe = (k == 40) ? 3'd6 : 3'(k % 6);
            tick();
            if (k == 39) check("wrap_busy_before_trig", {31'd0, busy}, 32'd1);
        end
        check("wrap_done", {31'd0, done}, 32'd1);
        check("wrap_trig_pos", {28'd0, trig_pos}, 32'd7);
        probe = 3'd7;
        tick(); tick();
        for (int i = 0; i < 16; i++)
            rd_check("wrap_rd", 4'(i), (i == 15) ? 3'd6 : 3'((25 + i) % 6));

        // Restart mid-POST, then arm coinciding with a matching sample
        saw_done = 1'b0;
        arm_with(4'd5, 3'b000, 3'b000, 1'b0, 3'd0);
        for (int k = 1; k <= 10; k++) begin
            tick();
            saw_done |= done;
            if (k == 6) check("rs_first_trig_pos", {28'd0, trig_pos}, 32'd5);
        end
        arm_with(4'd2, 3'b111, 3'b101, 1'b0, 3'b000);
        saw_done |= done;
        check("rs_busy_after_rearm", {31'd0, busy}, 32'd1);
        for (int k = 1; k <= 4; k++) begin
            probe = 3'b000;
            tick();
            saw_done |= done;
        end
        arm_with(4'd3, 3'b111, 3'b101, 1'b0, 3'b101);
        saw_done |= done;
        check("rs_arm_beats_fire", {28'd0, trig_pos}, 32'd5);
        check("rs_no_done_during_restarts", {31'd0, saw_done}, 32'd0);
        for (int k = 1; k <= 16; k++) begin
            probe = (k == 1) ? 3'b001 : (k == 2) ? 3'b010 : (k == 3) ? 3'b011 :
                    (k == 4) ? 3'b101 : 3'b100;
            tick();
            if (k == 4) check("rs_new_trig_pos", {28'd0, trig_pos}, 32'd3);
            if (k == 15) check("rs_done_before_end", {31'd0, done}, 32'd0);
        end
        check("rs_done", {31'd0, done}, 32'd1);
        for (int i = 0; i < 5; i++) rd_check("rs_rd", rst_tab[i].addr, rst_tab[i].exp);

        // Reset during a capture
        arm_with(4'd3, 3'b000, 3'b000, 1'b0, 3'd0);
        tick(); tick(); tick(); tick(); tick();
        sys_rst = 1'b1;
        tick(); tick();
        check("mrst_busy", {31'd0, busy}, 32'd0);
        check("mrst_done", {31'd0, done}, 32'd0);
        check("mrst_trig_pos", {28'd0, trig_pos}, 32'd0);
        check("mrst_rd_data", {29'd0, rd_data}, 32'd0);
        sys_rst = 1'b0;
        tick();

`ifdef LA_TRIG_CNT_EN
        // Third rising pulse fires when trig_cnt=2
        trig_cnt = 8'd2;
        arm_with(4'd0, 3'b001, 3'b001, 1'b1, 3'd0);
        for (int k = 1; k <= 24; k++) begin
            probe = (k == 3 || k == 6 || k == 9) ? 3'b001 : 3'b000;
            tick();
            if (k == 6) check("cnt_no_fire_second", {28'd0, trig_pos}, 32'd0);
            if (k == 9) check("cnt_trig_pos", {28'd0, trig_pos}, 32'd8);
            if (k == 23) check("cnt_done_before_end", {31'd0, done}, 32'd0);
        end
        check("cnt_done", {31'd0, done}, 32'd1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
